// File: rtl/trn_arb_pkg.sv
// rtl/trn_arb_pkg.sv - shared state encoding, arbitration modes and TRN idle pattern
package trn_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UPREQ = 3'd1,
        ST_GRANT = 3'd2,
        ST_DRIVE = 3'd3,
        ST_REL   = 3'd4
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // TRN idle pattern: data zero, rem all ones, active-low controls deasserted
    localparam logic TRN_TD_IDLE_BIT   = 1'b0;
    localparam logic TRN_TREM_IDLE_BIT = 1'b1;
    localparam logic TRN_CTL_IDLE_N    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request at or after a pointer, wrapping modulo NREQ
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [PW-1:0]   idx_o
);

    int rank;
    int best_rank;

    // Rank each requester by its distance from the pointer; the smallest set rank wins
    always_comb begin
        onehot_o  = '0;
        idx_o     = '0;
        rank      = 0;
        best_rank = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            rank = j - int'(ptr_i);
            if (rank < 0) begin
                rank = rank + NREQ;
            end
            if (req_i[j] && (rank < best_rank)) begin
                best_rank   = rank;
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/trn_tx_arb_n.sv
// rtl/trn_tx_arb_n.sv - NREQ-way TRN tx arbiter with upstream chaining, grant mux and watchdog
module trn_tx_arb_n
    import trn_arb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int DW       = 64,
    parameter int RW       = 8,
    parameter int ARB_MODE = 1,
    parameter int UPSTREAM = 1,
    parameter int GNT_TO   = 64,
    parameter int TOW      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_reqep,
    input  logic [NREQ-1:0]   req_drvn,
    output logic [NREQ-1:0]   req_trn,
    input  logic [NREQ*DW-1:0] in_trn_td,
    input  logic [NREQ*RW-1:0] in_trn_trem_n,
    input  logic [NREQ-1:0]   in_trn_tsof_n,
    input  logic [NREQ-1:0]   in_trn_teof_n,
    input  logic [NREQ-1:0]   in_trn_tsrc_rdy_n,
    output logic [DW-1:0]     trn_td,
    output logic [RW-1:0]     trn_trem_n,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    input  logic              chn_trn,
    output logic              chn_drvn,
    output logic              chn_reqep,
    output logic              gnt_timeout
);

    localparam int PW = $clog2(NREQ);
    localparam logic [TOW-1:0] WD_LAST = TOW'(GNT_TO - 1);

    arb_state_e      state_q;
    logic [PW-1:0]   sel_q;
    logic [NREQ-1:0] sel_oh_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [TOW-1:0]  wd_q;
    logic [NREQ-1:0] req_trn_q;
    logic            chn_drvn_q;
    logic            chn_reqep_q;
    logic            gnt_timeout_q;

    logic [PW-1:0]   pick_ptr_d;
    logic [PW-1:0]   pick_idx_d;
    logic [NREQ-1:0] pick_oh_d;
    logic            sel_req_d;
    logic            sel_drv_d;
    logic            up_lost_d;
    logic            mux_en_d;

    // Fixed priority is round-robin with the pointer pinned at requester 0
    assign pick_ptr_d = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i    (req_reqep),
        .ptr_i    (pick_ptr_d),
        .onehot_o (pick_oh_d),
        .idx_o    (pick_idx_d)
    );

    // Only the selected requester's handshake lines matter; others are masked off
    assign sel_req_d = |(req_reqep & sel_oh_q);
    assign sel_drv_d = |(req_drvn & sel_oh_q);
    assign up_lost_d = (UPSTREAM != 0) && !chn_trn;

    // Arbitration FSM with registered grant, chain and watchdog outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            sel_oh_q      <= '0;
            rr_ptr_q      <= '0;
            wd_q          <= '0;
            req_trn_q     <= '0;
            chn_drvn_q    <= 1'b0;
            chn_reqep_q   <= 1'b0;
            gnt_timeout_q <= 1'b0;
        end else begin
            gnt_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_reqep) begin
                        sel_q       <= pick_idx_d;
                        sel_oh_q    <= pick_oh_d;
                        chn_reqep_q <= 1'b1;
                        if (UPSTREAM != 0) begin
                            state_q <= ST_UPREQ;
                        end else begin
                            state_q    <= ST_GRANT;
                            req_trn_q  <= pick_oh_d;
                            chn_drvn_q <= 1'b1;
                        end
                    end
                end
                ST_UPREQ: begin
                    if (!sel_req_d) begin
                        state_q     <= ST_IDLE;
                        chn_reqep_q <= 1'b0;
                    end else if (chn_trn) begin
                        state_q    <= ST_GRANT;
                        req_trn_q  <= sel_oh_q;
                        chn_drvn_q <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // drvn beats a same-cycle watchdog expiry
                    if (sel_drv_d) begin
                        state_q     <= ST_DRIVE;
                        chn_reqep_q <= 1'b0;
                    end else if (wd_q == WD_LAST) begin
                        state_q       <= ST_REL;
                        gnt_timeout_q <= 1'b1;
                        req_trn_q     <= '0;
                        chn_drvn_q    <= 1'b0;
                        chn_reqep_q   <= 1'b0;
                    end else if (up_lost_d || !sel_req_d) begin
                        state_q     <= ST_REL;
                        req_trn_q   <= '0;
                        chn_drvn_q  <= 1'b0;
                        chn_reqep_q <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    // Upstream loss is ignored here so an in-flight TLP always completes
                    if (!sel_drv_d) begin
                        state_q    <= ST_REL;
                        req_trn_q  <= '0;
                        chn_drvn_q <= 1'b0;
                    end
                end
                ST_REL: begin
                    wd_q    <= '0;
                    state_q <= ST_IDLE;
                    if (ARB_MODE == ARB_RR) begin
                        rr_ptr_q <= (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_trn     = req_trn_q;
    assign chn_drvn    = chn_drvn_q;
    assign chn_reqep   = (UPSTREAM != 0) ? chn_reqep_q : 1'b0;
    assign gnt_timeout = gnt_timeout_q;

    assign mux_en_d = (state_q == ST_GRANT) || (state_q == ST_DRIVE);

    // Grant-selected TRN mux; shows the idle pattern whenever nobody holds the bus
    always_comb begin
        trn_td         = {DW{TRN_TD_IDLE_BIT}};
        trn_trem_n     = {RW{TRN_TREM_IDLE_BIT}};
        trn_tsof_n     = TRN_CTL_IDLE_N;
        trn_teof_n     = TRN_CTL_IDLE_N;
        trn_tsrc_rdy_n = TRN_CTL_IDLE_N;
        for (int j = 0; j < NREQ; j++) begin
            if (mux_en_d && sel_oh_q[j]) begin
                trn_td         = in_trn_td[j*DW +: DW];
                trn_trem_n     = in_trn_trem_n[j*RW +: RW];
                trn_tsof_n     = in_trn_tsof_n[j];
                trn_teof_n     = in_trn_teof_n[j];
                trn_tsrc_rdy_n = in_trn_tsrc_rdy_n[j];
            end
        end
    end

endmodule
